sram_loader_ram: RTL

Parametrised Wishbone word SRAM for the picorv32 SoC with an integrated byte-stream boot loader. It serves CPU instruction/data traffic on the Wishbone slave port. It also accepts a framed program image from an external UART receiver: sync word, base address, word count, payload, checksum. After a verified load it pulses a CPU reset. It supersedes the fixed-depth, fixed-origin programming SRAM.

---
 rtl/picorv32_pkg.sv | 35 +++
 rtl/sram_loader_ram_if.sv | 14 +
 rtl/sram_loader_fsm.sv | 194 +++++++++++++++++++
 rtl/sram_loader_ram.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/picorv32_pkg.sv
// Shared types for the picorv32 SoC: Wishbone request/response structs and boot-loader constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package picorv32_pkg;

    // Host-to-device Wishbone request
    typedef struct packed {
        logic [31:0] a_adr;
        logic [31:0] a_dat;
        logic [3:0]  a_sel;
        logic        a_we;
        logic        a_cyc;
        logic        a_stb;
    } wb_h2d_t;

    // Device-to-host Wishbone response
    typedef struct packed {
        logic [31:0] d_dat;
        logic        d_ack;
    } wb_d2h_t;

    // Frame sync word; the first character sits in the most significant byte
    localparam int                            LOADER_SYNC_LEN = 9;
    localparam logic [8*LOADER_SYNC_LEN-1:0] LOADER_SYNC     = "TEKNOFEST";

    typedef enum logic [2:0] {
        LS_IDLE  = 3'd0,
        LS_BASE  = 3'd1,
        LS_COUNT = 3'd2,
        LS_DATA  = 3'd3,
        LS_CHECK = 3'd4,
        LS_RESET = 3'd5
    } loader_state_e;

endpackage

// File: rtl/sram_loader_ram_if.sv
// Wishbone bundle between the CPU bus and the loader SRAM.
// Latency: n/a (wires only).
// Backpressure: slave holds off a request simply by not acking it.
// Members: wb_sram_i (request, master->slave), wb_sram_o (response, slave->master).
interface sram_loader_ram_if;
    import picorv32_pkg::*;

    wb_h2d_t wb_sram_i;
    wb_d2h_t wb_sram_o;

    modport master (output wb_sram_i, input  wb_sram_o);
    modport slave  (input  wb_sram_i, output wb_sram_o);

endinterface

// File: rtl/sram_loader_fsm.sv
// Boot-loader byte parser: sync hunt, base/count capture, payload words, checksum, CPU reset pulse.
// Latency: a payload word is presented on o_wr_* one cycle after its 4th byte.
// Backpressure: none; accepts one byte per cycle, frames stalled for SEQ_TIMEOUT cycles are aborted.
// Ports: clk_i/rst_i (sync, active-high); i_rx_data/i_rx_valid byte stream; i_range_err from the
//        RAM range check; o_wr_en/o_wr_addr(+o_wr_addr_hi carry)/o_wr_data write request;
//        o_frame_start pulse after sync; o_cpu_rst, o_prog_mode, o_load_err status.
module sram_loader_fsm
    import picorv32_pkg::*;
#(
    parameter int SEQ_TIMEOUT = 1000000,
    parameter int RST_CYCLES  = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    input  logic        i_range_err,
    output logic        o_wr_en,
    output logic [31:0] o_wr_addr,
    output logic        o_wr_addr_hi,
    output logic [31:0] o_wr_data,
    output logic        o_frame_start,
    output logic        o_cpu_rst,
    output logic        o_prog_mode,
    output logic        o_load_err
);

    localparam logic [2:0] ST_IDLE  = LS_IDLE;
    localparam logic [2:0] ST_BASE  = LS_BASE;
    localparam logic [2:0] ST_COUNT = LS_COUNT;
    localparam logic [2:0] ST_DATA  = LS_DATA;
    localparam logic [2:0] ST_CHECK = LS_CHECK;
    localparam logic [2:0] ST_RESET = LS_RESET;

    localparam int TW = $clog2(SEQ_TIMEOUT + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);

    logic [2:0]                     r_state;
    logic [8*LOADER_SYNC_LEN-1:0]   r_shift;
    logic [1:0]                     r_bcnt;
    logic [31:0]                    r_base;
    logic [31:0]                    r_count;
    logic [31:0]                    r_word;
    logic [32:0]                    r_addr;   // 33 bits so base+i never wraps
    logic [31:0]                    r_wcnt;
    logic [7:0]                     r_sum;
    logic [TW-1:0]                  r_tmo;
    logic [RW-1:0]                  r_rcnt;
    logic                           r_wr_en;
    logic [32:0]                    r_wr_addr;
    logic [31:0]                    r_wr_data;
    logic                           r_load_err;
    logic                           r_start;

    logic [8*LOADER_SYNC_LEN-1:0]   w_shift_nxt;
    logic [31:0]                    w_base_nxt;
    logic [31:0]                    w_count_nxt;
    logic [31:0]                    w_word_nxt;
    logic                           w_active;
    logic                           w_timeout;

    assign w_shift_nxt = {r_shift[8*LOADER_SYNC_LEN-9:0], i_rx_data};
    assign w_base_nxt  = {r_base[23:0],  i_rx_data};
    assign w_count_nxt = {r_count[23:0], i_rx_data};
    assign w_word_nxt  = {r_word[23:0],  i_rx_data};

    assign w_active  = (r_state == ST_BASE) || (r_state == ST_COUNT) ||
                       (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_timeout = w_active && !i_rx_valid && (r_tmo == TW'(SEQ_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bcnt     <= '0;
            r_base     <= '0;
            r_count    <= '0;
            r_word     <= '0;
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_sum      <= '0;
            r_tmo      <= '0;
            r_rcnt     <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_load_err <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_start <= 1'b0;

            // Inter-byte idle counter, only meaningful inside a frame
            if (w_active && !i_rx_valid) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        // Sliding-window match includes the byte arriving this cycle
                        if (w_shift_nxt == LOADER_SYNC) begin
                            r_state    <= ST_BASE;
                            r_shift    <= '0;
                            r_bcnt     <= '0;
                            r_sum      <= '0;
                            r_load_err <= 1'b0;
                            r_start    <= 1'b1;
                        end else begin
                            r_shift <= w_shift_nxt;
                        end
                    end
                end
                ST_BASE: begin
                    if (i_rx_valid) begin
                        r_base <= w_base_nxt;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_state <= ST_COUNT;
                        end
                    end
                end
                ST_COUNT: begin
                    if (i_rx_valid) begin
                        r_count <= w_count_nxt;
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_addr  <= {1'b0, r_base};
                            r_wcnt  <= '0;
                            r_state <= (w_count_nxt == 32'd0) ? ST_CHECK : ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_rx_valid) begin
                        r_word <= w_word_nxt;
                        r_sum  <= r_sum + i_rx_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (r_bcnt == 2'd3) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= w_word_nxt;
                            r_addr    <= r_addr + 33'd1;
                            r_wcnt    <= r_wcnt + 32'd1;
                            if (r_wcnt == r_count - 32'd1) begin
                                r_state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (i_rx_valid) begin
                        // i_range_err already covers a dropped final word written this cycle
                        if ((i_rx_data == r_sum) && !i_range_err) begin
                            r_state <= ST_RESET;
                            r_rcnt  <= '0;
                        end else begin
                            r_load_err <= 1'b1;
                            r_state    <= ST_IDLE;
                        end
                    end
                end
                ST_RESET: begin
                    if (r_rcnt == RW'(RST_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rcnt <= r_rcnt + RW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A stalled frame overrides whatever the state machine decided
            if (w_timeout) begin
                r_state    <= ST_IDLE;
                r_load_err <= 1'b1;
            end
        end
    end

    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr[31:0];
    assign o_wr_addr_hi  = r_wr_addr[32];
    assign o_wr_data     = r_wr_data;
    assign o_frame_start = r_start;
    assign o_cpu_rst     = (r_state == ST_RESET);
    assign o_prog_mode   = w_active;
    assign o_load_err    = r_load_err;

endmodule

// File: rtl/sram_loader_ram.sv
// Wishbone word SRAM with an integrated UART-fed boot loader that pulses the CPU reset after a good load.
// Latency: Wishbone ack READ_LATENCY cycles after accept; loader word written 1 cycle after its 4th byte.
// Backpressure: a loader write steals the RAM port for one cycle; the Wishbone request waits, unacked.
// Ports: clk_i/rst_i (sync, active-high); wb_sram (Wishbone slave: request in, d_dat/d_ack out);
//        rx_data_i/rx_valid_i byte stream; cpu_rst_o, prog_mode_o, load_err_o loader status.
module sram_loader_ram
    import picorv32_pkg::*;
#(
    parameter int    RAM_DEPTH    = 131072,
    parameter string INIT_FILE    = "",
    parameter int    READ_LATENCY = 1,
    parameter int    SEQ_TIMEOUT  = 1000000,
    parameter int    RST_CYCLES   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sram_loader_ram_if.slave         wb_sram,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_valid_i,
    output logic                     cpu_rst_o,
    output logic                     prog_mode_o,
    output logic                     load_err_o
);

    localparam int AW = $clog2(RAM_DEPTH);

    logic [31:0]    r_mem [RAM_DEPTH];
    logic [31:0]    r_rd;
    logic           r_ack;
    logic           r_range_err;

    wb_h2d_t        w_req;
    wb_d2h_t        w_rsp;
    logic [AW-1:0]  w_wb_idx;
    logic [AW-1:0]  w_ld_idx;
    logic           w_acc;
    logic           w_busy;
    logic [31:0]    w_dat;

    logic           w_wr_en;
    logic [31:0]    w_wr_addr;
    logic           w_wr_hi;
    logic [31:0]    w_wr_data;
    logic           w_frame_start;
    logic           w_ld_in_range;
    logic           w_ld_wr;
    logic           w_unused;

    sram_loader_fsm #(
        .SEQ_TIMEOUT (SEQ_TIMEOUT),
        .RST_CYCLES  (RST_CYCLES)
    ) u_fsm (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_rx_data     (rx_data_i),
        .i_rx_valid    (rx_valid_i),
        .i_range_err   (r_range_err | (w_wr_en & ~w_ld_in_range)),
        .o_wr_en       (w_wr_en),
        .o_wr_addr     (w_wr_addr),
        .o_wr_addr_hi  (w_wr_hi),
        .o_wr_data     (w_wr_data),
        .o_frame_start (w_frame_start),
        .o_cpu_rst     (cpu_rst_o),
        .o_prog_mode   (prog_mode_o),
        .o_load_err    (load_err_o)
    );

    assign w_req    = wb_sram.wb_sram_i;
    assign w_wb_idx = w_req.a_adr[AW+1:2];
    assign w_ld_idx = w_wr_addr[AW-1:0];
    assign w_unused = &{1'b0, w_req.a_adr[31:AW+2], w_req.a_adr[1:0]};

    // Full 33-bit compare: words past the top are dropped rather than wrapped
    assign w_ld_in_range = ({w_wr_hi, w_wr_addr} < 33'(RAM_DEPTH));
    assign w_ld_wr       = w_wr_en & w_ld_in_range;

    // Loader owns the port when it writes; the bus request simply waits
    assign w_acc = w_req.a_cyc & w_req.a_stb & ~w_busy & ~r_ack & ~w_ld_wr & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (w_ld_wr) begin
            r_mem[w_ld_idx] <= w_wr_data;
        end else if (w_acc && w_req.a_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req.a_sel[b]) begin
                    r_mem[w_wb_idx][8*b +: 8] <= w_req.a_dat[8*b +: 8];
                end
            end
        end
        if (w_acc) begin
            r_rd <= r_mem[w_wb_idx];
        end
    end

    // Range error lives for one frame; cleared as the new frame starts
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_range_err <= 1'b0;
        end else if (w_frame_start) begin
            r_range_err <= 1'b0;
        end else if (w_wr_en && !w_ld_in_range) begin
            r_range_err <= 1'b1;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic        r_pend;
        logic [31:0] r_dat;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_pend <= 1'b0;
                r_ack  <= 1'b0;
                r_dat  <= '0;
            end else begin
                r_pend <= w_acc;
                r_ack  <= r_pend;
                if (r_pend) begin
                    r_dat <= r_rd;
                end
            end
        end

        assign w_busy = r_pend;
        assign w_dat  = r_dat;
    end else begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_ack <= 1'b0;
            end else begin
                r_ack <= w_acc;
            end
        end

        assign w_busy = 1'b0;
        // RAM output register has no reset, so gate it to keep d_dat at zero outside acks
        assign w_dat  = r_ack ? r_rd : 32'h0;
    end

    always_comb begin
        w_rsp       = '0;
        w_rsp.d_dat = w_dat;
        w_rsp.d_ack = r_ack;
    end

    assign wb_sram.wb_sram_o = w_rsp;

endmodule
